// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, transmit-scheduler state encoding and
// the PID byte builder (upper nibble is the ones-complement check field).
package usb_pkg;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PID     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_TAIL    = 3'd3,
    S_GAP     = 3'd4
  } tx_state_e;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_ipg_timer.sv
// Inter-packet gap down-counter: load_i presets 4*IPG_BITS-1, the count then
// runs down to zero and holds; expired_o is high while the count is zero.
module usb_ipg_timer #(
  parameter int unsigned IPG_BITS = 2
) (
  input  logic clk_48,
  input  logic rst_n,
  input  logic load_i,
  output logic expired_o
);

  localparam int unsigned CYCLES = 4 * IPG_BITS;
  localparam int unsigned CW     = $clog2(CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: load has priority, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = LOAD_VAL;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/usb_tx_sched.sv
// Packet sequencer ahead of the bit-level USB transmitter. Grants one of the
// handshake or data requesters, feeds PID and payload bytes on transmitter
// strobes, steers CRC16 update/append, waits out the inter-packet gap and
// pulses the matching done. Optional macro USB_TX_SCHED_ABORT_EN adds an
// abort input that truncates the packet without a CRC.
module usb_tx_sched
  import usb_pkg::*;
#(
  parameter int unsigned IPG_BITS = 2
) (
  input  logic       clk_48,
  input  logic       rst_n,
`ifdef USB_TX_SCHED_ABORT_EN
  input  logic       abort,
`endif
  input  logic       hs_req,
  input  logic [3:0] hs_pid,
  output logic       hs_done,
  input  logic       data_req,
  input  logic [3:0] data_pid,
  input  logic       data_zlp,
  input  logic [7:0] data_byte,
  input  logic       data_last,
  output logic       data_pop,
  output logic       data_done,
  output logic       busy,
  output logic       tx_transmit,
  output logic [7:0] tx_data,
  output logic       tx_update_crc16,
  output logic       tx_send_crc16,
  input  logic       tx_data_strobe,
  input  logic       tx_en
);

  tx_state_e  state_q, state_d;
  logic       grant_data_q, grant_data_d;   // 1: data packet, 0: handshake
  logic       transmit_q, transmit_d;
  logic [7:0] data_q, data_d;
  logic       send_crc_q, send_crc_d;
  logic       last_q, last_d;               // loaded byte is the final one
  logic       load_pend_q, load_pend_d;     // fetch next byte after a pop
  logic       seen_en_q, seen_en_d;         // tx_en observed high this packet
  logic       gap_load;
  logic       gap_expired;
  logic       abort_w;

`ifdef USB_TX_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  usb_ipg_timer #(.IPG_BITS(IPG_BITS)) u_ipg_timer (
    .clk_48   (clk_48),
    .rst_n    (rst_n),
    .load_i   (gap_load),
    .expired_o(gap_expired)
  );

  // Next-state, datapath and pulse outputs for the packet sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    grant_data_d = grant_data_q;
    transmit_d   = transmit_q;
    data_d       = data_q;
    send_crc_d   = send_crc_q;
    last_d       = last_q;
    load_pend_d  = load_pend_q;
    seen_en_d    = seen_en_q;
    gap_load     = 1'b0;
    data_pop     = 1'b0;
    hs_done      = 1'b0;
    data_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!tx_en && (hs_req || data_req)) begin
          grant_data_d = !hs_req;
          data_d       = pid_byte(hs_req ? hs_pid : data_pid);
          transmit_d   = 1'b1;
          send_crc_d   = !hs_req;
          seen_en_d    = 1'b0;
          load_pend_d  = 1'b0;
          state_d      = S_PID;
        end
      end
      S_PID: begin
        seen_en_d = seen_en_q | tx_en;
        if (abort_w) begin
          transmit_d = 1'b0;
          send_crc_d = 1'b0;
          state_d    = S_TAIL;
        end else if (tx_data_strobe) begin
          if (!grant_data_q || data_zlp) begin
            transmit_d = 1'b0;
            state_d    = S_TAIL;
          end else begin
            data_d  = data_byte;
            last_d  = data_last;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        seen_en_d = seen_en_q | tx_en;
        if (abort_w) begin
          transmit_d  = 1'b0;
          send_crc_d  = 1'b0;
          load_pend_d = 1'b0;
          state_d     = S_TAIL;
        end else if (tx_data_strobe) begin
          data_pop = 1'b1;
          if (last_q) begin
            transmit_d = 1'b0;
            state_d    = S_TAIL;
          end else begin
            load_pend_d = 1'b1;
          end
        end else if (load_pend_q) begin
          // Source has advanced past the popped byte by now.
          data_d      = data_byte;
          last_d      = data_last;
          load_pend_d = 1'b0;
        end
      end
      S_TAIL: begin
        seen_en_d = seen_en_q | tx_en;
        if (seen_en_q && !tx_en) begin
          gap_load   = 1'b1;
          send_crc_d = 1'b0;
          seen_en_d  = 1'b0;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_expired) begin
          hs_done   = !grant_data_q;
          data_done = grant_data_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_data_q <= 1'b0;
      transmit_q   <= 1'b0;
      data_q       <= 8'h00;
      send_crc_q   <= 1'b0;
      last_q       <= 1'b0;
      load_pend_q  <= 1'b0;
      seen_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      transmit_q   <= transmit_d;
      data_q       <= data_d;
      send_crc_q   <= send_crc_d;
      last_q       <= last_d;
      load_pend_q  <= load_pend_d;
      seen_en_q    <= seen_en_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign tx_transmit     = transmit_q;
  assign tx_data         = data_q;
  assign tx_update_crc16 = (state_q == S_PAYLOAD);
  assign tx_send_crc16   = send_crc_q;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Self-checking bench for usb_tx_sched: emulates the bit transmitter
// (tx_en, byte strobes) and a payload source, and compares every strobed
// byte, CRC control, pop count and done timing with expectations derived
// from packet contents. Define USB_TX_SCHED_ABORT_EN to cover abort.
module tb_usb_tx_sched;

  localparam int IPG_BITS = 2;
  localparam int GAP_CYC  = 4 * IPG_BITS;

  logic       clk_48 = 1'b0;
  logic       rst_n  = 1'b0;
  logic       abort  = 1'b0;
  logic       hs_req = 1'b0;
  logic [3:0] hs_pid = 4'h0;
  logic       hs_done;
  logic       data_req = 1'b0;
  logic [3:0] data_pid = 4'h0;
  logic       data_zlp = 1'b0;
  logic [7:0] data_byte = 8'h00;
  logic       data_last = 1'b0;
  logic       data_pop;
  logic       data_done;
  logic       busy;
  logic       tx_transmit;
  logic [7:0] tx_data;
  logic       tx_update_crc16;
  logic       tx_send_crc16;
  logic       tx_data_strobe = 1'b0;
  logic       tx_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [7:0] payload [0:15];
  int src_idx = 0;
  int src_n   = 0;
  int last_wait = 0;

  always #10 clk_48 = ~clk_48;

  usb_tx_sched #(.IPG_BITS(IPG_BITS)) dut (
    .clk_48         (clk_48),
    .rst_n          (rst_n),
`ifdef USB_TX_SCHED_ABORT_EN
    .abort          (abort),
`endif
    .hs_req         (hs_req),
    .hs_pid         (hs_pid),
    .hs_done        (hs_done),
    .data_req       (data_req),
    .data_pid       (data_pid),
    .data_zlp       (data_zlp),
    .data_byte      (data_byte),
    .data_last      (data_last),
    .data_pop       (data_pop),
    .data_done      (data_done),
    .busy           (busy),
    .tx_transmit    (tx_transmit),
    .tx_data        (tx_data),
    .tx_update_crc16(tx_update_crc16),
    .tx_send_crc16  (tx_send_crc16),
    .tx_data_strobe (tx_data_strobe),
    .tx_en          (tx_en)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    data_byte = (src_idx < src_n) ? payload[src_idx] : 8'h00;
    data_last = (src_idx == src_n - 1);
  endtask

  // Runs one packet through the emulated transmitter and checks it.
  task automatic run_packet(input bit is_data, input logic [3:0] pid, input bit zlp,
                            input int n, input bit do_abort);
    logic [7:0] exp_bytes [0:16];
    int  exp_n, exp_pops, strobes, pops, phase, cnt, period, lat, waitc;
    bit  pop_seen, finished, aborted, exp_crc;

    exp_bytes[0] = {~pid, pid};
    for (int i = 0; i < n; i++) exp_bytes[i+1] = payload[i];
    exp_pops = (is_data && !zlp) ? n : 0;
    exp_n    = 1 + exp_pops;
    exp_crc  = is_data;
    if (do_abort) begin
      exp_n = 2; exp_pops = 1; exp_crc = 1'b0;
    end

    src_n = n; src_idx = 0; drive_src();
    if (is_data) begin
      data_pid = pid; data_zlp = zlp; data_req = 1'b1;
    end else begin
      hs_pid = pid; hs_req = 1'b1;
    end

    strobes = 0; pops = 0; phase = 0; cnt = 0; lat = 0; waitc = 0;
    pop_seen = 0; finished = 0; aborted = 0;
    period = $urandom_range(3, 8);

    for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
      @(posedge clk_48); #1;
      if (pop_seen) begin
        src_idx++; drive_src(); pop_seen = 0;
      end
      tx_data_strobe = 1'b0;
      abort = 1'b0;
      case (phase)
        0: begin
          waitc++;
          if (tx_transmit) begin
            tx_en = 1'b1; phase = 1; cnt = period;
          end
        end
        1: begin
          if (!tx_transmit) begin
            check("send_crc_tail", tx_send_crc16, exp_crc);
            phase = 2; cnt = 2;
          end else if (do_abort && !aborted && strobes == 2) begin
            abort = 1'b1; aborted = 1;
          end else if (cnt == 0) begin
            tx_data_strobe = 1'b1;
            if (strobes < exp_n) begin
              check("byte", tx_data, exp_bytes[strobes]);
              check("upd_crc", tx_update_crc16, strobes > 0);
              check("send_crc", tx_send_crc16, is_data);
            end else begin
              check("extra_strobe", strobes, exp_n);
            end
            strobes++;
            cnt = period;
          end else begin
            cnt--;
          end
        end
        2: begin
          if (cnt == 0) begin
            tx_en = 1'b0; phase = 3; lat = 0;
          end else cnt--;
        end
        default: lat++;
      endcase
      #1;
      if (data_pop) begin
        if (tx_data_strobe) pop_seen = 1;
        pops++;
      end
      if (phase == 3 && (hs_done || data_done)) begin
        check("done_kind", {hs_done, data_done}, is_data ? 2'b01 : 2'b10);
        check("done_latency", lat, GAP_CYC);
        if (is_data) data_req = 1'b0; else hs_req = 1'b0;
        finished = 1;
      end
    end
    check("finished", finished, 1'b1);
    check("strobes", strobes, exp_n);
    check("pops", pops, exp_pops);
    last_wait = waitc;
    tx_data_strobe = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    logic [3:0] hs_pids [0:2];
    logic [3:0] pid;
    int n;
    hs_pids[0] = 4'b0010; hs_pids[1] = 4'b1010; hs_pids[2] = 4'b1110;

    // Reset state.
    #35;
    check("rst_transmit", tx_transmit, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_send_crc", tx_send_crc16, 1'b0);
    check("rst_done", {hs_done, data_done, data_pop}, 3'b000);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_48);

    // Handshake ACK: D2, no CRC.
    run_packet(1'b0, 4'b0010, 1'b0, 0, 1'b0);

    // DATA0 with 01, 02.
    payload[0] = 8'h01; payload[1] = 8'h02;
    run_packet(1'b1, 4'b0011, 1'b0, 2, 1'b0);

    // DATA1 zero-length: 4B only, CRC appended.
    run_packet(1'b1, 4'b1011, 1'b1, 0, 1'b0);

    // Simultaneous NAK and DATA0: handshake first, then gap, then data.
    payload[0] = 8'hA5; payload[1] = 8'h3C; payload[2] = 8'h7E;
    src_n = 3; src_idx = 0; drive_src();
    @(posedge clk_48); #1;
    data_pid = 4'b0011; data_zlp = 1'b0; data_req = 1'b1;
    hs_pid = 4'b1010; hs_req = 1'b1;
    run_packet(1'b0, 4'b1010, 1'b0, 0, 1'b0);
    run_packet(1'b1, 4'b0011, 1'b0, 3, 1'b0);
    check("ipg_gap", last_wait >= 2, 1'b1);

    // Request while the line is busy elsewhere: no transmit until tx_en falls.
    @(posedge clk_48); #1;
    tx_en = 1'b1; hs_pid = 4'b1110; hs_req = 1'b1;
    begin
      bit saw_tx = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk_48); #1;
        if (tx_transmit) saw_tx = 1;
      end
      check("blocked_by_tx_en", saw_tx, 1'b0);
    end
    tx_en = 1'b0;
    run_packet(1'b0, 4'b1110, 1'b0, 0, 1'b0);

    // Randomized packets against the content-derived model.
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        run_packet(1'b0, hs_pids[$urandom_range(0, 2)], 1'b0, 0, 1'b0);
      end else begin
        n   = $urandom_range(1, 6);
        pid = ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b1011;
        for (int i = 0; i < n; i++) payload[i] = 8'($urandom);
        run_packet(1'b1, pid, ($urandom_range(0, 4) == 0), n, 1'b0);
      end
    end

`ifdef USB_TX_SCHED_ABORT_EN
    // Abort after the first payload strobe: no CRC, no further pops.
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    run_packet(1'b1, 4'b0011, 1'b0, 3, 1'b1);
`endif

    @(posedge clk_48); #1;
    check("idle_at_end", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
